z80_mcycle_sequencer: RTL and testbench

Sequences Z80 machine cycles on the external memory bus. It takes one M-cycle request at a time (opcode fetch with refresh, memory read, or memory write) and steps through T1/T2/Tw/T3/T4, driving the active-low bus strobes. It honours `wait_n`, returns read data, and reports the T-state count consumed. It sits between the instruction decoder/microsequencer and the pins, and produces the `mcycle_type`/`tcycles` values that the z80fi spec checks (e.g. M1 = 4, memory read = 3).

---
 rtl/z80_mcycle_sequencer_pkg.sv | 24 ++
 rtl/z80_mcycle_sequencer.sv | 155 +++++++++++++++
 tb/tb_z80_mcycle_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/z80_mcycle_sequencer_pkg.sv
// rtl/z80_mcycle_sequencer_pkg.sv - shared encodings for the Z80 M-cycle sequencer
package z80_mcycle_sequencer_pkg;

   // Machine-cycle request types
   localparam logic [2:0] CYCLE_NONE     = 3'd0;
   localparam logic [2:0] CYCLE_M1       = 3'd1;
   localparam logic [2:0] CYCLE_RDWR_MEM = 3'd2;

   // Sequencer T-state encodings; the formal harness references these names
   typedef enum logic [2:0] {
      TSTATE_IDLE = 3'd0,
      TSTATE_T1   = 3'd1,
      TSTATE_T2   = 3'd2,
      TSTATE_TW   = 3'd3,
      TSTATE_T3   = 3'd4,
      TSTATE_T4   = 3'd5
   } tstate_t;

   // Only real bus cycles are accepted; CYCLE_NONE and unused codes are ignored
   function automatic logic is_valid_cycle(input logic [2:0] t);
      return (t == CYCLE_M1) || (t == CYCLE_RDWR_MEM);
   endfunction

endpackage

// File: rtl/z80_mcycle_sequencer.sv
// rtl/z80_mcycle_sequencer.sv - Z80 machine-cycle bus sequencer (M1/read/write)
module z80_mcycle_sequencer
   import z80_mcycle_sequencer_pkg::*;
#(
   parameter int WAIT_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [2:0]            cycle_type,
   input  logic                  write,
   input  logic [15:0]           addr,
   input  logic [7:0]            wdata,
   input  logic [15:0]           refresh_addr,
   input  logic                  wait_n,
   input  logic [7:0]            bus_din,
   output logic [15:0]           bus_addr,
   output logic [7:0]            bus_dout,
   output logic                  mreq_n,
   output logic                  rd_n,
   output logic                  wr_n,
   output logic                  m1_n,
   output logic                  rfsh_n,
   output logic                  ready,
   output logic                  done,
   output logic [7:0]            rdata,
   output logic [WAIT_CNT_W-1:0] tcycles,
   output logic [2:0]            cur_type
);

   tstate_t               r_state;
   tstate_t               w_next_state;
   logic [2:0]            r_type;
   logic                  r_write;
   logic [15:0]           r_addr;
   logic [15:0]           r_refresh_addr;
   logic [7:0]            r_wdata;
   logic [7:0]            r_rdata;
   logic [WAIT_CNT_W-1:0] r_tcnt;
   logic [WAIT_CNT_W-1:0] r_tcycles;
   logic                  w_is_m1;
   logic                  w_done_state;
   logic                  w_ready;
   logic                  w_accept;

   assign w_is_m1      = (r_type == CYCLE_M1);
   // The final T-state of a cycle: T4 for M1, T3 for plain memory cycles
   assign w_done_state = (r_state == TSTATE_T4) || ((r_state == TSTATE_T3) && !w_is_m1);
   assign w_ready      = (r_state == TSTATE_IDLE) || w_done_state;
   assign w_accept     = start && w_ready && is_valid_cycle(cycle_type);

   assign ready    = w_ready;
   assign done     = w_done_state;
   assign rdata    = r_rdata;
   assign tcycles  = r_tcycles;
   assign cur_type = (r_state == TSTATE_IDLE) ? CYCLE_NONE : r_type;

   // T-state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= TSTATE_IDLE;
      else          r_state <= w_next_state;
   end

   // Next T-state and bus strobe decode from the registered state
   always_comb begin
      w_next_state = r_state;
      mreq_n       = 1'b1;
      rd_n         = 1'b1;
      wr_n         = 1'b1;
      m1_n         = 1'b1;
      rfsh_n       = 1'b1;
      bus_addr     = '0;
      bus_dout     = '0;

      case (r_state)
         TSTATE_IDLE: if (w_accept) w_next_state = TSTATE_T1;
         TSTATE_T1:   w_next_state = TSTATE_T2;
         TSTATE_T2,
         TSTATE_TW:   w_next_state = wait_n ? TSTATE_T3 : TSTATE_TW;
         TSTATE_T3:   w_next_state = w_is_m1 ? TSTATE_T4 :
                                     (w_accept ? TSTATE_T1 : TSTATE_IDLE);
         TSTATE_T4:   w_next_state = w_accept ? TSTATE_T1 : TSTATE_IDLE;
         default:     w_next_state = TSTATE_IDLE;
      endcase

      if (r_state != TSTATE_IDLE) begin
         if (w_is_m1) begin
            if ((r_state == TSTATE_T3) || (r_state == TSTATE_T4)) begin
               // Refresh half of the opcode fetch drives {I,R}
               mreq_n   = 1'b0;
               rfsh_n   = 1'b0;
               bus_addr = r_refresh_addr;
            end else begin
               mreq_n   = 1'b0;
               rd_n     = 1'b0;
               m1_n     = 1'b0;
               bus_addr = r_addr;
            end
         end else if (r_state != TSTATE_T4) begin
            mreq_n   = 1'b0;
            bus_addr = r_addr;
            if (r_write) begin
               bus_dout = r_wdata;
               wr_n     = (r_state == TSTATE_T1);
            end else begin
               rd_n     = 1'b0;
            end
         end
      end
   end

   // Request capture on acceptance
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_type         <= CYCLE_NONE;
         r_write        <= 1'b0;
         r_addr         <= '0;
         r_wdata        <= '0;
         r_refresh_addr <= '0;
      end else if (w_accept) begin
         r_type         <= cycle_type;
         r_write        <= write;
         r_addr         <= addr;
         r_wdata        <= wdata;
         r_refresh_addr <= refresh_addr;
      end
   end

   // Saturating T-state counter and completed-cycle length
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tcnt    <= '0;
         r_tcycles <= '0;
      end else begin
         if (w_accept)
            r_tcnt <= WAIT_CNT_W'(1);
         else if ((r_state != TSTATE_IDLE) && (r_tcnt != '1))
            r_tcnt <= r_tcnt + WAIT_CNT_W'(1);
         if (w_done_state)
            r_tcycles <= r_tcnt;
      end
   end

   // Read data latch: opcode entering T3, memory read leaving T3
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rdata <= '0;
      end else if (w_is_m1 && ((r_state == TSTATE_T2) || (r_state == TSTATE_TW)) && wait_n) begin
         r_rdata <= bus_din;
      end else if (!w_is_m1 && !r_write && (r_state == TSTATE_T3)) begin
         r_rdata <= bus_din;
      end
   end

endmodule

// File: tb/tb_z80_mcycle_sequencer.sv
// tb/tb_z80_mcycle_sequencer.sv - randomized self-checking bench for z80_mcycle_sequencer
module tb_z80_mcycle_sequencer;
   import z80_mcycle_sequencer_pkg::*;

   localparam int W    = 8;
   localparam int CMAX = 255;

   typedef struct {
      logic [2:0]  typ;
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [15:0] rf;
      int          k;      // number of TW states to insert
      int          gap;    // idle cycles before start (0 = back-to-back)
      bit          wjunk;  // hold wait_n low in phases where it is ignored
   } txn_t;

   logic          clk = 1'b0;
   logic          reset_n, start, write, wait_n;
   logic [2:0]    cycle_type, cur_type;
   logic [15:0]   addr, refresh_addr, bus_addr;
   logic [7:0]    wdata, bus_din, bus_dout, rdata;
   logic          mreq_n, rd_n, wr_n, m1_n, rfsh_n, ready, done;
   logic [W-1:0]  tcycles;

   always #5 clk = ~clk;

   z80_mcycle_sequencer #(.WAIT_CNT_W(W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .cycle_type(cycle_type),
      .write(write), .addr(addr), .wdata(wdata), .refresh_addr(refresh_addr),
      .wait_n(wait_n), .bus_din(bus_din), .bus_addr(bus_addr), .bus_dout(bus_dout),
      .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n),
      .ready(ready), .done(done), .rdata(rdata), .tcycles(tcycles), .cur_type(cur_type)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: position within the current cycle and its total length
   bit         m_active;
   int         m_p, m_L;
   txn_t       m_t;
   logic [7:0] m_rdata;
   int         m_tcycles;

   function automatic bit m_ready();
      return !m_active || (m_p == m_L - 1);
   endfunction

   task automatic check_outputs();
      logic [4:0] es;
      bit         rd_phase;
      es = 5'b11111;   // {mreq_n, rd_n, wr_n, m1_n, rfsh_n}
      if (m_active) begin
         if (m_t.typ == CYCLE_M1) begin
            rd_phase = (m_p <= m_t.k + 1);
            es = rd_phase ? 5'b00101 : 5'b01110;
            check("bus_addr", bus_addr, rd_phase ? m_t.addr : m_t.rf);
         end else if (m_t.wr) begin
            es = (m_p == 0) ? 5'b01111 : 5'b01011;
            check("bus_addr", bus_addr, m_t.addr);
            check("bus_dout", bus_dout, m_t.wdata);
         end else begin
            es = 5'b00111;
            check("bus_addr", bus_addr, m_t.addr);
         end
      end
      check("strobes", {mreq_n, rd_n, wr_n, m1_n, rfsh_n}, es);
      check("done", done, m_active && (m_p == m_L - 1));
      check("ready", ready, m_ready());
      check("cur_type", cur_type, m_active ? m_t.typ : CYCLE_NONE);
      check("rdata", rdata, m_rdata);
      check("tcycles", tcycles, m_tcycles);
   endtask

   // One clock: check current outputs, drive inputs, advance the model across the edge
   task automatic cycle(input bit st, input txn_t t);
      @(negedge clk);
      check_outputs();
      if (st) begin
         start = 1'b1; cycle_type = t.typ; write = t.wr;
         addr = t.addr; wdata = t.wdata; refresh_addr = t.rf;
      end else begin
         start        = 1'($urandom_range(0, 1));
         cycle_type   = m_ready() ? CYCLE_NONE : 3'($urandom_range(0, 2));
         write        = 1'($urandom_range(0, 1));
         addr         = 16'($urandom);
         wdata        = 8'($urandom);
         refresh_addr = 16'($urandom);
      end
      bus_din = 8'($urandom);
      if (m_active && (m_p >= 1) && (m_p <= m_t.k))
         wait_n = 1'b0;
      else if (m_active && (m_p == m_t.k + 1))
         wait_n = 1'b1;
      else
         wait_n = (m_active && m_t.wjunk) ? 1'b0 : 1'($urandom_range(0, 1));

      if (m_active) begin
         if ((m_t.typ == CYCLE_M1) && (m_p == m_t.k + 1)) m_rdata = bus_din;
         if (m_p == m_L - 1) begin
            if ((m_t.typ != CYCLE_M1) && !m_t.wr) m_rdata = bus_din;
            m_tcycles = (m_L > CMAX) ? CMAX : m_L;
            m_active  = 1'b0;
         end
         m_p++;
      end
      if (st) begin
         m_active = 1'b1;
         m_t      = t;
         m_p      = 0;
         m_L      = ((t.typ == CYCLE_M1) ? 4 : 3) + t.k;
      end
   endtask

   function automatic txn_t mk(input logic [2:0] typ, input logic wr, input logic [15:0] a,
                               input logic [7:0] d, input logic [15:0] rf, input int k,
                               input int gap, input bit wjunk);
      txn_t t;
      t.typ = typ; t.wr = wr; t.addr = a; t.wdata = d; t.rf = rf;
      t.k = k; t.gap = gap; t.wjunk = wjunk;
      return t;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      txn_t q[$];
      txn_t dummy;
      txn_t t;

      dummy = mk(CYCLE_NONE, 1'b0, 16'h0, 8'h0, 16'h0, 0, 0, 1'b0);
      reset_n = 1'b0; start = 1'b0; cycle_type = CYCLE_NONE; write = 1'b0;
      addr = '0; wdata = '0; refresh_addr = '0; wait_n = 1'b1; bus_din = '0;
      m_active = 1'b0; m_p = 0; m_L = 0; m_rdata = '0; m_tcycles = 0; m_t = dummy;

      repeat (2) @(negedge clk);
      check_outputs();
      check("rst_bus_addr", bus_addr, 16'h0);
      check("rst_bus_dout", bus_dout, 8'h0);
      reset_n = 1'b1;

      q.push_back(mk(CYCLE_M1,       1'b0, 16'h1234, 8'h00, 16'h3F05, 0, 1, 1'b0));
      q.push_back(mk(CYCLE_RDWR_MEM, 1'b0, 16'h8000, 8'h00, 16'h0000, 2, 1, 1'b0));
      q.push_back(mk(CYCLE_RDWR_MEM, 1'b1, 16'h4000, 8'hA5, 16'h0000, 0, 1, 1'b0));
      q.push_back(mk(CYCLE_M1,       1'b0, 16'h0100, 8'h00, 16'h0A11, 0, 1, 1'b0));
      q.push_back(mk(CYCLE_RDWR_MEM, 1'b0, 16'hC000, 8'h00, 16'h0000, 0, 0, 1'b0));
      q.push_back(mk(CYCLE_M1,       1'b0, 16'h2222, 8'h00, 16'h1E7F, 0, 2, 1'b1));
      q.push_back(mk(CYCLE_RDWR_MEM, 1'b0, 16'h5A5A, 8'h00, 16'h0000, 300, 0, 1'b0));
      for (int i = 0; i < 40; i++) begin
         q.push_back(mk($urandom_range(0, 1) ? CYCLE_M1 : CYCLE_RDWR_MEM,
                        1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 16'($urandom),
                        $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1))));
      end

      foreach (q[i]) begin
         while (!m_ready()) cycle(1'b0, dummy);
         repeat (q[i].gap) cycle(1'b0, dummy);
         cycle(1'b1, q[i]);
      end
      while (m_active) cycle(1'b0, dummy);
      cycle(1'b0, dummy);

      // Abort a read in TW with an asynchronous reset
      t = mk(CYCLE_RDWR_MEM, 1'b0, 16'h7777, 8'h00, 16'h0000, 6, 0, 1'b0);
      cycle(1'b1, t);
      while (m_p < 3) cycle(1'b0, dummy);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      m_active = 1'b0; m_rdata = '0; m_tcycles = 0;
      check_outputs();
      check("abort_bus_addr", bus_addr, 16'h0);
      check("abort_bus_dout", bus_dout, 8'h0);
      @(posedge clk);
      #2 reset_n = 1'b1;
      t = mk(CYCLE_M1, 1'b0, 16'h0042, 8'h00, 16'h0101, 1, 0, 1'b0);
      cycle(1'b1, t);
      while (m_active) cycle(1'b0, dummy);
      cycle(1'b0, dummy);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
